// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  // Requester indices into the per-requester vectors
  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned REQ_LD  = 0;
  localparam int unsigned REQ_ALU = 1;
  localparam int unsigned REQ_LNK = 2;

  // Fixed architectural registers
  localparam logic [3:0] LINK_REG = 4'd14;
  localparam logic [3:0] PC_REG   = 4'd15;

endpackage

// File: rtl/regfile_wb_arbiter_age_counter.sv
// Saturating wait counter for one writeback requester. The counter runs while
// the requester is valid but not granted; it reports "aged" once it reaches
// the promotion threshold.
module wb_age_counter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic valid,
  input  logic grant,
  output logic aged
);

  localparam logic [WAIT_W-1:0] CNT_MAX = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] AGE_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

  logic [WAIT_W-1:0] cnt_r;

  // Count denied cycles, clearing on grant, idle or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (flush || grant || !valid) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign aged = valid && (cnt_r >= AGE_LIM);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the load unit,
// the ALU and the branch-link path, and tracks pending writes for decode.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [3:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [3:0]        alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lnk_valid,
  input  logic [DATA_W-1:0] lnk_data,
  output logic              lnk_ready,
  input  logic              alloc_valid,
  input  logic [3:0]        alloc_addr,
  input  logic              flush,
  output logic              reg_write,
  output logic [3:0]        write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       busy
);

  logic [NUM_REQ-1:0] valid_s;
  logic [NUM_REQ-1:0] aged_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               any_grant_s;
  logic [3:0]         grant_addr_s;
  logic [DATA_W-1:0]  grant_data_s;
  logic [15:0]        busy_next_s;
  logic [15:0]        busy_r;
  logic               reg_write_r;
  logic [3:0]         write_addr_r;
  logic [DATA_W-1:0]  write_data_r;

  assign valid_s[REQ_LD]  = ld_valid;
  assign valid_s[REQ_ALU] = alu_valid;
  assign valid_s[REQ_LNK] = lnk_valid;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_age
    wb_age_counter #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
    ) u_age (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .valid (valid_s[g]),
      .grant (grant_s[g]),
      .aged  (aged_s[g])
    );
  end

  // Priority select: aged requesters first, then base order ld > alu > lnk
  always_comb begin
    grant_s = '0;
    if (rst) begin
      grant_s = '0;
    end else if (|aged_s) begin
      if (aged_s[REQ_LD])       grant_s[REQ_LD]  = 1'b1;
      else if (aged_s[REQ_ALU]) grant_s[REQ_ALU] = 1'b1;
      else                      grant_s[REQ_LNK] = 1'b1;
    end else begin
      if (valid_s[REQ_LD])       grant_s[REQ_LD]  = 1'b1;
      else if (valid_s[REQ_ALU]) grant_s[REQ_ALU] = 1'b1;
      else if (valid_s[REQ_LNK]) grant_s[REQ_LNK] = 1'b1;
      else                       grant_s = '0;
    end
  end

  assign ld_ready    = grant_s[REQ_LD];
  assign alu_ready   = grant_s[REQ_ALU];
  assign lnk_ready   = grant_s[REQ_LNK];
  assign any_grant_s = |grant_s;

  // Route the granted requester's destination and data to the write port
  always_comb begin
    grant_addr_s = ld_addr;
    grant_data_s = ld_data;
    if (grant_s[REQ_ALU]) begin
      grant_addr_s = alu_addr;
      grant_data_s = alu_data;
    end else if (grant_s[REQ_LNK]) begin
      grant_addr_s = LINK_REG;
      grant_data_s = lnk_data;
    end else begin
      grant_addr_s = ld_addr;
      grant_data_s = ld_data;
    end
  end

  // Scoreboard next state: flush wins, then alloc (new producer), then grant clears
  always_comb begin
    busy_next_s = busy_r;
    for (int n = 0; n < 16; n++) begin
      if (flush) begin
        busy_next_s[n] = 1'b0;
      end else if (alloc_valid && (alloc_addr == 4'(n))) begin
        busy_next_s[n] = 1'b1;
      end else if (any_grant_s && (grant_addr_s == 4'(n))) begin
        busy_next_s[n] = 1'b0;
      end else begin
        busy_next_s[n] = busy_r[n];
      end
    end
  end

  // Register the scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 16'h0000;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Register the write port; address and data hold when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_r  <= 1'b0;
      write_addr_r <= 4'd0;
      write_data_r <= '0;
    end else if (any_grant_s) begin
      reg_write_r  <= 1'b1;
      write_addr_r <= grant_addr_s;
      write_data_r <= grant_data_s;
    end else begin
      reg_write_r  <= 1'b0;
      write_addr_r <= write_addr_r;
      write_data_r <= write_data_r;
    end
  end

  assign reg_write  = reg_write_r;
  assign write_addr = write_addr_r;
  assign write_data = write_data_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lnk_valid;
  logic [31:0] lnk_data;
  logic        lnk_ready;
  logic        alloc_valid;
  logic [3:0]  alloc_addr;
  logic        flush;
  logic        reg_write;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic [15:0] busy;

  int tests_run;
  int tests_failed;

  regfile_wb_arbiter #(
    .DATA_W   (32),
    .MAX_WAIT (4),
    .WAIT_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .alu_valid   (alu_valid),
    .alu_addr    (alu_addr),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .lnk_valid   (lnk_valid),
    .lnk_data    (lnk_data),
    .lnk_ready   (lnk_ready),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .flush       (flush),
    .reg_write   (reg_write),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .busy        (busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    ld_valid = 1'b0; ld_addr = 4'd0; ld_data = 32'h0;
    alu_valid = 1'b0; alu_addr = 4'd0; alu_data = 32'h0;
    lnk_valid = 1'b0; lnk_data = 32'h0;
    alloc_valid = 1'b0; alloc_addr = 4'd0; flush = 1'b0;

    // Reset state
    #2;
    check_eq("rst_reg_write", 32'(reg_write), 32'd0);
    check_eq("rst_addr", 32'(write_addr), 32'd0);
    check_eq("rst_data", write_data, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single ALU request
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'hDEAD_BEEF;
    settle();
    check_eq("t1_alu_ready", 32'(alu_ready), 32'd1);
    check_eq("t1_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    check_eq("t1_reg_write", 32'(reg_write), 32'd1);
    check_eq("t1_addr", 32'(write_addr), 32'd3);
    check_eq("t1_data", write_data, 32'hDEAD_BEEF);
    tick();
    check_eq("t1_idle_we", 32'(reg_write), 32'd0);
    check_eq("t1_hold_addr", 32'(write_addr), 32'd3);
    check_eq("t1_hold_data", write_data, 32'hDEAD_BEEF);

    // All three requesters: ld, alu, lnk in order
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'h0000_1111;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h0000_2222;
    lnk_valid = 1'b1; lnk_data = 32'h0000_3333;
    settle();
    check_eq("t2_ready_c0", {29'd0, lnk_ready, alu_ready, ld_ready}, 32'b001);
    tick();
    ld_valid = 1'b0;
    check_eq("t2_addr_ld", 32'(write_addr), 32'd1);
    check_eq("t2_data_ld", write_data, 32'h0000_1111);
    settle();
    check_eq("t2_ready_c1", {29'd0, lnk_ready, alu_ready, ld_ready}, 32'b010);
    tick();
    alu_valid = 1'b0;
    check_eq("t2_addr_alu", 32'(write_addr), 32'd2);
    check_eq("t2_data_alu", write_data, 32'h0000_2222);
    settle();
    check_eq("t2_ready_c2", {29'd0, lnk_ready, alu_ready, ld_ready}, 32'b100);
    tick();
    lnk_valid = 1'b0;
    check_eq("t2_we_lnk", 32'(reg_write), 32'd1);
    check_eq("t2_addr_lnk", 32'(write_addr), 32'd14);
    check_eq("t2_data_lnk", write_data, 32'h0000_3333);
    tick();

    // Aging: alu promoted after four denied cycles
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 32'h0000_4444;
    ld_valid = 1'b1; ld_addr = 4'd6;
    for (int i = 0; i < 4; i++) begin
      ld_data = 32'h6000_0000 + 32'(i);
      settle();
      check_eq($sformatf("t3_alu_denied_%0d", i), 32'(alu_ready), 32'd0);
      check_eq($sformatf("t3_ld_grant_%0d", i), 32'(ld_ready), 32'd1);
      tick();
      check_eq($sformatf("t3_ld_data_%0d", i), write_data, 32'h6000_0000 + 32'(i));
    end
    ld_data = 32'h6000_0004;
    settle();
    check_eq("t3_alu_aged", 32'(alu_ready), 32'd1);
    check_eq("t3_ld_blocked", 32'(ld_ready), 32'd0);
    tick();
    check_eq("t3_alu_addr", 32'(write_addr), 32'd4);
    check_eq("t3_alu_data", write_data, 32'h0000_4444);
    // Counter cleared by the grant: a fresh alu request loses to ld again
    alu_data = 32'h0000_4445;
    settle();
    check_eq("t3_alu_cleared", 32'(alu_ready), 32'd0);
    check_eq("t3_ld_again", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    tick();

    // Scoreboard set by alloc, cleared with the write
    alloc_valid = 1'b1; alloc_addr = 4'd5;
    tick();
    alloc_valid = 1'b0;
    check_eq("t4_busy_set", 32'(busy), 32'h0020);
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h0000_5555;
    tick();
    alu_valid = 1'b0;
    check_eq("t4_we", 32'(reg_write), 32'd1);
    check_eq("t4_busy_clr", 32'(busy), 32'h0000);

    // Alloc and grant to the same register in one cycle
    alloc_valid = 1'b1; alloc_addr = 4'd7;
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 32'h0000_7777;
    tick();
    alloc_valid = 1'b0; ld_valid = 1'b0;
    check_eq("t5_busy_kept", 32'(busy), 32'h0080);
    check_eq("t5_addr", 32'(write_addr), 32'd7);
    ld_valid = 1'b1; ld_data = 32'h0000_7778;
    tick();
    ld_valid = 1'b0;
    check_eq("t5_busy_clr", 32'(busy), 32'h0000);

    // Flush clears busy but not the granted write
    for (int r = 4; r < 8; r++) begin
      alloc_valid = 1'b1; alloc_addr = 4'(r);
      tick();
    end
    alloc_valid = 1'b0;
    check_eq("t6_busy_pre", 32'(busy), 32'h00F0);
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_addr = 4'd9;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 32'h0000_2002;
    settle();
    check_eq("t6_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    flush = 1'b0; alloc_valid = 1'b0; alu_valid = 1'b0;
    check_eq("t6_busy_flushed", 32'(busy), 32'h0000);
    check_eq("t6_we", 32'(reg_write), 32'd1);
    check_eq("t6_addr", 32'(write_addr), 32'd2);
    check_eq("t6_data", write_data, 32'h0000_2002);
    tick();

    // Flush clears wait counters
    ld_valid = 1'b1; ld_addr = 4'd1; ld_data = 32'h0000_0001;
    alu_valid = 1'b1; alu_addr = 4'd8; alu_data = 32'h0000_0008;
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check_eq("t7_alu_not_aged", 32'(alu_ready), 32'd0);
    ld_valid = 1'b0; alu_valid = 1'b0;
    tick();

    // Reset mid-stream
    alloc_valid = 1'b1; alloc_addr = 4'd3;
    alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 32'h0000_9999;
    tick();
    alloc_valid = 1'b0;
    check_eq("t8_we_pre", 32'(reg_write), 32'd1);
    check_eq("t8_busy_pre", 32'(busy), 32'h0008);
    rst = 1'b1;
    settle();
    check_eq("t8_rst_we", 32'(reg_write), 32'd0);
    check_eq("t8_rst_addr", 32'(write_addr), 32'd0);
    check_eq("t8_rst_data", write_data, 32'h0);
    check_eq("t8_rst_busy", 32'(busy), 32'h0);
    check_eq("t8_rst_ready", 32'(alu_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    rst = 1'b0;
    tick();
    check_eq("t8_post_we", 32'(reg_write), 32'd0);
    check_eq("t8_post_addr", 32'(write_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (reg_write/write_addr/write_data) between three writeback requesters: load unit, ALU, and branch-link (R14 ← return PC).
- Uses fixed priority with an aging override so no requester starves.
- Keeps a 16-entry pending-write scoreboard that decode uses to stall on RAW hazards.
- Sits between the execute/memory stages and register_file.

Parameters:
- DATA_W, 32, width of write data.
- MAX_WAIT, 4, cycles a requester may wait before it is promoted to top priority (must be ≥1).
- WAIT_W, 3, width of each wait counter (must hold MAX_WAIT).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ld_valid  in  1  load writeback request
- ld_addr  in  4  load destination register
- ld_data  in  DATA_W  load result
- ld_ready  out  1  load request granted this cycle
- alu_valid  in  1  ALU writeback request
- alu_addr  in  4  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request granted this cycle
- lnk_valid  in  1  link writeback request; destination is fixed to 4'd14
- lnk_data  in  DATA_W  return PC
- lnk_ready  out  1  link request granted this cycle
- alloc_valid  in  1  decode issues an instruction that will write alloc_addr
- alloc_addr  in  4  destination being allocated
- flush  in  1  pipeline flush
- reg_write  out  1  write enable to register file
- write_addr  out  4  register file write address
- write_data  out  DATA_W  register file write data
- busy  out  16  bit n = 1 means a write to register n is pending

Behaviour:
- Reset (async): reg_write=0, write_addr=0, write_data=0, busy=16'h0000, all wait counters 0. Ready outputs are 0 because no requester can be valid-qualified while in reset.
- Handshake:
  - *_ready is combinational from the valid inputs and wait counters.
  - A transfer occurs when valid && ready.
  - At most one ready is high per cycle. Ready is never high without its valid.
  - A requester must hold valid, addr and data stable until granted.
- Priority:
  - Base order is ld > alu > lnk.
  - Any requester whose wait counter ≥ MAX_WAIT is "aged". If one or more requesters are aged, the highest-base-priority aged requester wins over all non-aged requesters.
- Wait counters (one per requester):
  - valid && !ready → increment, saturating at 2^WAIT_W-1.
  - Grant or !valid → clear to 0.
- Write port output (registered, 1-cycle latency):
  - On a grant at edge N, the outputs after edge N+1 are reg_write=1, write_addr = granted address (14 for lnk), write_data = granted data.
  - With no grant, reg_write=0 and write_addr/write_data hold their previous values.
  - Address 15 is forwarded unchanged; register_file converts it to pc_write.
- Scoreboard, per bit n, evaluated each edge:
  - set if alloc_valid && alloc_addr==n;
  - else clear if a grant this cycle targets n;
  - else hold.
  - Alloc and grant to the same n in the same cycle → bit ends at 1 (the new producer wins).
  - Alloc to an already-busy n → stays 1; there is no counting and decode must not allocate a busy register.
  - busy reflects the registered state. The cleared bit is visible on the same edge that reg_write asserts, so the write and the ready indication coincide.
- Flush:
  - Synchronous. Clears busy to 0 and all wait counters to 0.
  - A grant occurring in the flush cycle still completes to the write port; flush does not cancel granted writes.
  - alloc_valid is ignored in the flush cycle.
- Reset mid-operation: the pending output write is dropped, and no write issues until the first grant after rst deasserts.

Decomposition:
- Shared package holds:
  - requester index constants REQ_LD=0, REQ_ALU=1, REQ_LNK=2;
  - LINK_REG=4'd14;
  - PC_REG=4'd15.
- One sub-module, wb_age_counter: a saturating wait counter with clear/increment and an aged flag output, instantiated three times.
- Priority select and scoreboard stay in the top level.

Test Plan:
- Single ALU request, alu_addr=3, alu_data=32'hDEAD_BEEF → alu_ready=1 same cycle. Next cycle: reg_write=1, write_addr=3, write_data=32'hDEAD_BEEF.
- ld, alu and lnk all valid and held → grant order ld, alu, lnk over three cycles. Write port shows ld_addr, alu_addr, then 14 with lnk_data.
- ld_valid held every cycle with new data while alu_valid held → alu_ready asserts after exactly MAX_WAIT=4 denied cycles, then its counter clears.
- alloc_valid with alloc_addr=5 → busy[5]=1. Later ALU grant to addr 5 → busy[5]=0 on the same edge that reg_write=1.
- In the same cycle, alloc_addr=7 and an ld grant to addr 7 → busy[7] remains 1.
- busy=16'h00F0 and flush plus alu grant to addr 2 → busy=0, and the write to addr 2 still appears next cycle. Separately, asserting rst mid-stream → all outputs 0 immediately.
